// File: rtl/spectro_line_capture_pkg.sv
// Shared sizing constants and FSM state encoding for the spectrometer line capture block.
package spectro_line_capture_pkg;

    localparam int DEF_NPIX      = 288;
    localparam int DEF_DW        = 12;
    localparam int DEF_AW        = 9;
    localparam int DEF_START_DLY = 2;
    localparam int DLY_W         = 8;
    localparam int CNT_W         = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELAY   = 2'd1,
        CAPTURE = 2'd2,
        SWAP    = 2'd3
    } capState_t;

endpackage

// File: rtl/spectro_line_capture_line_buf_2bank.sv
// Two-bank simple dual-port line buffer: one write port, one registered read port.
module line_buf_2bank
    import spectro_line_capture_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic          i_clk,
    input  logic          i_wrEn,
    input  logic [AW:0]   i_wrAddr,
    input  logic [DW-1:0] i_wrData,
    input  logic [AW:0]   i_rdAddr,
    output logic [DW-1:0] o_rdData
);

    localparam int DEPTH = 2 ** (AW + 1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdData;

    // No reset on the array or read register so the block maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
        r_rdData <= r_mem[i_rdAddr];
    end

    assign o_rdData = r_rdData;

endmodule

// File: rtl/spectro_line_capture.sv
// Captures one delayed line of ADC samples per trigger into a ping-pong buffer
// and hands completed lines to the readout side.
module spectro_line_capture
    import spectro_line_capture_pkg::*;
#(
    parameter int NPIX      = DEF_NPIX,
    parameter int DW        = DEF_DW,
    parameter int AW        = DEF_AW,
    parameter int START_DLY = DEF_START_DLY
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_trig,
    input  logic             i_tick,
    input  logic [DW-1:0]    i_adcData,
    input  logic [AW-1:0]    i_rdAddr,
    output logic [DW-1:0]    o_rdData,
    output logic             o_lineReady,
    input  logic             i_lineAck,
    output logic             o_busy,
    output logic             o_overrun,
    output logic             o_trigErr,
    output logic [CNT_W-1:0] o_lineCount
);

    capState_t          r_state;
    capState_t          w_nextState;
    logic [DLY_W-1:0]   r_dly;
    logic [AW-1:0]      r_pix;
    logic               r_wrBank;
    logic               r_lineReady;
    logic               r_overrun;
    logic               r_trigErr;
    logic [CNT_W-1:0]   r_lineCount;
    logic               w_wrEn;
    logic               w_accept;
    logic               w_busy;

    assign w_busy = (r_state != IDLE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A tick in the accepting trig cycle is ignored because IDLE never samples.
    always_comb begin
        w_nextState = r_state;
        w_wrEn      = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_trig) begin
                    w_accept    = 1'b1;
                    w_nextState = (START_DLY == 0) ? CAPTURE : DELAY;
                end
            end
            DELAY: begin
                if (i_tick && (r_dly == DLY_W'(1))) begin
                    w_nextState = CAPTURE;
                end
            end
            CAPTURE: begin
                if (i_tick) begin
                    w_wrEn = 1'b1;
                    if (r_pix == AW'(NPIX - 1)) begin
                        w_nextState = SWAP;
                    end
                end
            end
            SWAP: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_dly       <= '0;
            r_pix       <= '0;
            r_wrBank    <= 1'b0;
            r_lineReady <= 1'b0;
            r_overrun   <= 1'b0;
            r_trigErr   <= 1'b0;
            r_lineCount <= '0;
        end else begin
            if (w_accept) begin
                r_dly <= DLY_W'(START_DLY);
                r_pix <= '0;
            end
            if ((r_state == DELAY) && i_tick) begin
                r_dly <= r_dly - DLY_W'(1);
            end
            if (w_wrEn) begin
                r_pix <= r_pix + AW'(1);
            end
            // The swap beats a same-cycle ack, so the new line stays flagged.
            if (r_state == SWAP) begin
                r_wrBank    <= ~r_wrBank;
                r_lineReady <= 1'b1;
                r_lineCount <= r_lineCount + CNT_W'(1);
                if (r_lineReady && !i_lineAck) begin
                    r_overrun <= 1'b1;
                end
            end else if (i_lineAck) begin
                r_lineReady <= 1'b0;
                r_overrun   <= 1'b0;
                r_trigErr   <= 1'b0;
            end
            if (i_trig && w_busy) begin
                r_trigErr <= 1'b1;
            end
        end
    end

    line_buf_2bank #(
        .DW (DW),
        .AW (AW)
    ) u_lineBuf (
        .i_clk    (i_clk),
        .i_wrEn   (w_wrEn),
        .i_wrAddr ({r_wrBank, r_pix}),
        .i_wrData (i_adcData),
        .i_rdAddr ({~r_wrBank, i_rdAddr}),
        .o_rdData (o_rdData)
    );

    assign o_lineReady = r_lineReady;
    assign o_busy      = w_busy;
    assign o_overrun   = r_overrun;
    assign o_trigErr   = r_trigErr;
    assign o_lineCount = r_lineCount;

endmodule
